// File: rtl/mac_tx.sv
// rtl/mac_tx.sv - Ethernet MAC transmit stage: preamble/SFD, pad, CRC-32 FCS and IFG onto GMII
module mac_tx #(
  parameter int          PREAMBLE_LEN  = 7,
  parameter int          MIN_FRAME_LEN = 60,
  parameter int          MAX_FRAME_LEN = 1514,
  parameter int          IFG_CYCLES    = 12,
  parameter logic [15:0] TIMEOUT_MAX   = 16'hffff
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       mac_tx_req,
  output logic       mac_tx_ack,
  input  logic       mac_tx_ready,
  output logic       mac_data_req,
  input  logic [7:0] mac_tx_data_in,
  input  logic       mac_tx_end_in,
  output logic       mac_send_end,
  output logic       tx_trunc,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_ACK        = 4'd1;
  localparam logic [3:0] S_WAIT_READY = 4'd2;
  localparam logic [3:0] S_PREAMBLE   = 4'd3;
  localparam logic [3:0] S_DATA       = 4'd4;
  localparam logic [3:0] S_PAD        = 4'd5;
  localparam logic [3:0] S_FCS        = 4'd6;
  localparam logic [3:0] S_IFG        = 4'd7;
  localparam logic [3:0] S_END        = 4'd8;

  localparam logic [10:0] PRE_L    = 11'(PREAMBLE_LEN);
  localparam logic [10:0] DREQ_L   = 11'(PREAMBLE_LEN - 2);
  localparam logic [10:0] MIN_L    = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] MAX_L    = 11'(MAX_FRAME_LEN);
  localparam logic [10:0] IFG_L    = 11'(IFG_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_MAX - 16'd1);

  logic [3:0]  state;
  logic [10:0] cnt;
  logic [10:0] cnt_inc;
  logic [15:0] to_cnt;
  logic [31:0] crc;
  logic        end_flag;
  logic [7:0]  fcs_byte;

  // Reflected CRC-32 (poly 0x04C11DB7), one byte per call.
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign cnt_inc = cnt + 11'd1;

  always_comb begin
    fcs_byte = 8'h00;
    case (cnt[1:0])
      2'd0:    fcs_byte = ~crc[7:0];
      2'd1:    fcs_byte = ~crc[15:8];
      2'd2:    fcs_byte = ~crc[23:16];
      default: fcs_byte = ~crc[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= S_IDLE;
      cnt          <= 11'd0;
      to_cnt       <= 16'd0;
      crc          <= 32'hFFFFFFFF;
      end_flag     <= 1'b0;
      mac_tx_ack   <= 1'b0;
      mac_data_req <= 1'b0;
      mac_send_end <= 1'b0;
      tx_trunc     <= 1'b0;
      gmii_tx_en   <= 1'b0;
      gmii_txd     <= 8'h00;
    end else begin
      mac_tx_ack   <= 1'b0;
      mac_data_req <= 1'b0;
      mac_send_end <= 1'b0;
      tx_trunc     <= 1'b0;
      gmii_tx_en   <= 1'b0;
      gmii_txd     <= 8'h00;
      to_cnt       <= 16'd0;
      case (state)
        S_IDLE: begin
          if (mac_tx_req) begin
            state      <= S_ACK;
            mac_tx_ack <= 1'b1;
          end
        end
        S_ACK: state <= S_WAIT_READY;
        S_WAIT_READY: begin
          to_cnt <= to_cnt + 16'd1;
          if (mac_tx_ready) begin
            state    <= S_PREAMBLE;
            cnt      <= 11'd0;
            crc      <= 32'hFFFFFFFF;
            end_flag <= 1'b0;
          end else if (to_cnt == TO_LAST) begin
            state <= S_IDLE;
          end
        end
        S_PREAMBLE: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= (cnt == PRE_L) ? 8'hD5 : 8'h55;
          // A source end marker during preamble makes the first data byte the last.
          end_flag     <= end_flag | mac_tx_end_in;
          mac_data_req <= (cnt == DREQ_L);
          if (cnt == PRE_L) begin
            state <= S_DATA;
            cnt   <= 11'd0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_DATA: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= mac_tx_data_in;
          crc        <= crc_next(crc, mac_tx_data_in);
          cnt        <= cnt_inc;
          end_flag   <= mac_tx_end_in;
          if (end_flag || cnt_inc == MAX_L) begin
            tx_trunc <= !end_flag && (cnt_inc == MAX_L);
            if (cnt_inc < MIN_L) begin
              state <= S_PAD;
            end else begin
              state <= S_FCS;
              cnt   <= 11'd0;
            end
          end
        end
        S_PAD: begin
          gmii_tx_en <= 1'b1;
          crc        <= crc_next(crc, 8'h00);
          cnt        <= cnt_inc;
          if (cnt_inc == MIN_L) begin
            state <= S_FCS;
            cnt   <= 11'd0;
          end
        end
        S_FCS: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= fcs_byte;
          cnt        <= cnt_inc;
          if (cnt[1:0] == 2'd3) begin
            state <= S_IFG;
            cnt   <= 11'd0;
          end
        end
        S_IFG: begin
          cnt <= cnt_inc;
          if (cnt == IFG_L) state <= S_END;
        end
        S_END: begin
          mac_send_end <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx.sv
// tb/tb_mac_tx.sv - directed self-checking bench for mac_tx
module tb_mac_tx;

  logic       clk = 1'b0;
  logic       rstn, req, ready, end_in;
  logic [7:0] din;

  logic       a_ack, a_dreq, a_send_end, a_trunc, a_tx_en;
  logic [7:0] a_txd;
  logic       b_ack, b_dreq, b_send_end, b_trunc, b_tx_en;
  logic [7:0] b_txd;

  always #5 clk = ~clk;

  mac_tx u_dut (
    .clk(clk), .rstn(rstn), .mac_tx_req(req), .mac_tx_ack(a_ack),
    .mac_tx_ready(ready), .mac_data_req(a_dreq), .mac_tx_data_in(din),
    .mac_tx_end_in(end_in), .mac_send_end(a_send_end), .tx_trunc(a_trunc),
    .gmii_tx_en(a_tx_en), .gmii_txd(a_txd)
  );

  mac_tx #(.MIN_FRAME_LEN(9)) u_min9 (
    .clk(clk), .rstn(rstn), .mac_tx_req(req), .mac_tx_ack(b_ack),
    .mac_tx_ready(ready), .mac_data_req(b_dreq), .mac_tx_data_in(din),
    .mac_tx_end_in(end_in), .mac_send_end(b_send_end), .tx_trunc(b_trunc),
    .gmii_tx_en(b_tx_en), .gmii_txd(b_txd)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] wire_a[$];
  logic [7:0] wire_b[$];
  logic [7:0] src[$];
  logic prev_en = 1'b0;
  logic mon_on = 1'b0;
  int rise_cnt = 0, en_first = 0, en_last = 0, idle_bad = 0;
  int trunc_cnt = 0, send_cnt = 0, send_cyc = 0, ack_cnt = 0, ack_cyc = 0;
  int base_a, base_b, rise0, trunc0, dreq_cyc;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_on) begin
      if (a_tx_en) begin
        wire_a.push_back(a_txd);
        if (!prev_en) begin
          rise_cnt++;
          en_first = cyc;
        end
        en_last = cyc;
      end else if (a_txd !== 8'h00) begin
        idle_bad++;
      end
      prev_en = a_tx_en;
      if (b_tx_en) wire_b.push_back(b_txd);
      if (a_trunc) trunc_cnt++;
      if (a_send_end) begin
        send_cnt++;
        send_cyc = cyc;
      end
      if (a_ack) begin
        ack_cnt++;
        ack_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC, one bit at a time (LSB first).
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
    logic fb;
    for (int j = 0; j < 8; j++) begin
      fb = c[0] ^ b[j];
      c = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  task automatic fill_src(input int n, input int seed);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(8'((i * 37 + seed) & 8'hFF));
  endtask

  // endpos: index carrying the end pulse; -1 = during preamble; -2 = never.
  task automatic run_frame(input int endpos);
    bit ok;
    int s0;
    base_a = wire_a.size();
    base_b = wire_b.size();
    rise0  = rise_cnt;
    trunc0 = trunc_cnt;
    s0     = send_cnt;
    req = 1'b1;
    ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = a_ack;
    end
    req = 1'b0;
    chk("ack_seen", ok, 1);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (a_dreq) begin
        ok = 1'b1;
        dreq_cyc = cyc;
      end
    end
    chk("data_req_seen", ok, 1);
    @(posedge clk); #1;
    end_in = (endpos == -1);
    @(posedge clk); #1;
    for (int i = 0; i < src.size(); i++) begin
      din = src[i];
      end_in = (i == endpos);
      @(posedge clk); #1;
    end
    din = 8'h00;
    end_in = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = (send_cnt > s0);
    end
    chk("send_end_seen", ok, 1);
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    logic [7:0] e[$];
    logic [31:0] c;
    logic [7:0] b;
    int nd, mism;
    for (int i = 0; i < 7; i++) e.push_back(8'h55);
    e.push_back(8'hD5);
    nd = (src.size() > 1514) ? 1514 : src.size();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < ((nd < 60) ? 60 : nd); i++) begin
      b = (i < nd) ? src[i] : 8'h00;
      e.push_back(b);
      c = ref_crc(c, b);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) e.push_back(c[8*k +: 8]);
    chk({tag, "_len"}, wire_a.size() - base_a, e.size());
    mism = 0;
    foreach (e[i]) if (base_a + i >= wire_a.size() || wire_a[base_a + i] !== e[i]) mism++;
    chk({tag, "_bytes_wrong"}, mism, 0);
  endtask

  initial begin
    int a_first, ack0, send0;
    bit ok;
    rstn = 1'b0; req = 1'b0; ready = 1'b0; din = 8'h00; end_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {a_ack, a_dreq, a_send_end, a_trunc, a_tx_en, a_txd}, 0);
    rstn = 1'b1;
    mon_on = 1'b1;

    fill_src(64, 3);
    run_frame(62);
    check_frame("f64");
    chk("f64_en_cycles", en_last - en_first + 1, 76);
    chk("f64_en_rises", rise_cnt - rise0, 1);
    chk("f64_dreq_offset", dreq_cyc - en_first, 5);
    chk("f64_send_end_delay", send_cyc - en_last, 13);
    chk("f64_trunc", trunc_cnt - trunc0, 0);

    src.delete();
    for (int i = 0; i < 9; i++) src.push_back(8'(8'h31 + i));
    run_frame(7);
    chk("crc9_len", wire_b.size() - base_b, 21);
    chk("crc9_fcs", {wire_b[base_b+17], wire_b[base_b+18], wire_b[base_b+19], wire_b[base_b+20]}, 32'h2639F4CB);
    check_frame("pad9");

    fill_src(20, 11);
    run_frame(18);
    check_frame("pad20");

    fill_src(1, 90);
    run_frame(-1);
    check_frame("end_in_pre");

    fill_src(1600, 5);
    run_frame(-2);
    check_frame("trunc");
    chk("trunc_pulses", trunc_cnt - trunc0, 1);

    fill_src(1515, 8);
    run_frame(1513);
    check_frame("trunc_end");
    chk("trunc_end_pulses", trunc_cnt - trunc0, 1);

    fill_src(1514, 2);
    run_frame(1512);
    check_frame("exact_max");
    chk("exact_max_trunc", trunc_cnt - trunc0, 0);

    // Readiness never arrives: FSM must give up and re-grant a held request.
    rise0 = rise_cnt; send0 = send_cnt; ack0 = ack_cnt;
    req = 1'b1; ready = 1'b0;
    ok = 1'b0; a_first = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = a_ack;
      a_first = cyc;
    end
    chk("to_first_ack", ok, 1);
    ok = 1'b0;
    for (int i = 0; i < 70000 && !ok; i++) begin
      @(negedge clk);
      ok = (ack_cnt >= ack0 + 2);
    end
    @(negedge clk);
    chk("to_second_ack", ok, 1);
    chk("to_ack_gap", ack_cyc - a_first, 65537);
    chk("to_no_tx_en", rise_cnt - rise0, 0);
    chk("to_no_send_end", send_cnt - send0, 0);
    req = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Reset in the middle of DATA.
    req = 1'b1; ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = a_ack;
    end
    req = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_mid_active", a_tx_en, 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_en_txd", {a_tx_en, a_txd}, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    fill_src(20, 77);
    run_frame(18);
    check_frame("post_rst");

    chk("idle_txd_zero", idle_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_tx.md
Name: mac_tx

Overview:
- Ethernet MAC transmit stage. It sits directly downstream of the IP/ARP frame builders and drives the GMII transmit pins.
- Per frame it accepts one request and fetches the byte stream (MAC header onward) from the source with a single data-request pulse.
- It prepends preamble and SFD, pads the frame to the minimum length, appends the CRC-32 FCS, enforces the inter-frame gap, then signals completion.

Parameters:
- PREAMBLE_LEN, 7: number of 0x55 bytes before the SFD (0xD5).
- MIN_FRAME_LEN, 60: minimum bytes before the FCS; shorter frames are padded with 0x00.
- MAX_FRAME_LEN, 1514: maximum bytes before the FCS; excess is truncated.
- IFG_CYCLES, 12: idle cycles after the last FCS byte.
- TIMEOUT_MAX, 16'hffff: readiness wait limit, in cycles.

Ports:
- clk  in  1  system/GMII tx clock.
- rstn  in  1  synchronous active-low reset.
- mac_tx_req  in  1  frame send request (level).
- mac_tx_ack  out  1  one-cycle grant of mac_tx_req.
- mac_tx_ready  in  1  source has frame data available.
- mac_data_req  out  1  one-cycle pulse; source starts streaming.
- mac_tx_data_in  in  8  frame byte from source.
- mac_tx_end_in  in  1  pulse one cycle before the source's final byte.
- mac_send_end  out  1  one-cycle pulse: frame plus IFG complete.
- tx_trunc  out  1  one-cycle pulse: MAX_FRAME_LEN truncation occurred.
- gmii_tx_en  out  1  GMII transmit enable (registered).
- gmii_txd  out  8  GMII transmit data (registered).

Behaviour:
- Reset (rstn=0 at a clock edge):
  - All outputs go to 0 at that edge; state returns to IDLE.
  - A frame in progress is abandoned and gmii_tx_en is low from that edge.
- States are IDLE, ACK, WAIT_READY, PREAMBLE, DATA, PAD, FCS, IFG, END.
- IDLE: when mac_tx_req=1, go to ACK.
- ACK: mac_tx_ack=1 for exactly this one cycle, then go to WAIT_READY.
- WAIT_READY:
  - A 16-bit timeout counter increments each cycle and is cleared outside this state.
  - mac_tx_ready=1 -> go to PREAMBLE with byte counter 0.
  - Counter reaches TIMEOUT_MAX -> go to IDLE, no pulse.
- PREAMBLE:
  - Emits PREAMBLE_LEN bytes of 0x55, then one 0xD5, with gmii_tx_en=1.
  - mac_data_req pulses in the cycle the registered output shows preamble byte index PREAMBLE_LEN-2, i.e. two cycles before the SFD appears.
  - The source presents its first byte two cycles after sampling mac_data_req. That byte is registered onto gmii_txd on the cycle after the SFD, with no gap.
- DATA:
  - Each cycle, mac_tx_data_in is registered to gmii_txd and folded into the CRC.
  - The 11-bit frame byte counter increments per byte.
  - When mac_tx_end_in is sampled high, the next byte is taken as the last.
  - After the last byte: if count < MIN_FRAME_LEN go to PAD, else go to FCS.
- PAD: emit 0x00 (included in the CRC) until the count equals MIN_FRAME_LEN, then go to FCS.
- FCS:
  - CRC is reflected CRC-32, polynomial 0x04C11DB7, initialised to 0xFFFFFFFF at PREAMBLE entry, updated one byte per cycle.
  - The FCS is ~crc, sent as 4 bytes, least-significant byte first.
- Truncation:
  - If the count reaches MAX_FRAME_LEN in DATA without an end marker, that byte is final, tx_trunc pulses, and the FSM goes to FCS.
  - Further source bytes are ignored.
- IFG: gmii_tx_en=0 and gmii_txd=0x00 for IFG_CYCLES cycles, then go to END.
- END: mac_send_end=1 for one cycle, then go to IDLE. mac_tx_req is not re-sampled until IDLE.
- Edge cases:
  - mac_tx_end_in while in PREAMBLE: the first data byte is also the last.
  - mac_tx_end_in high on the final truncated byte: tx_trunc still pulses.
  - mac_tx_req held high continuously: frames are back-to-back, separated by the full IFG.
- gmii_tx_en is high exactly from the first preamble byte through the last FCS byte, contiguously.

Test Plan:
- 64-byte source frame (end pulse on byte 62): gmii shows 55×7, D5, 64 bytes, 4 FCS bytes. gmii_tx_en is high for 76 cycles. mac_send_end pulses 12 cycles after tx_en falls plus 1.
- MIN_FRAME_LEN=9, bytes "123456789": FCS on the wire is 26 39 F4 CB, with no pad.
- 20-byte frame at default MIN_FRAME_LEN: 40 bytes of 0x00 follow, and the CRC covers 60 bytes (checked against a reference model).
- mac_tx_ready held low: mac_tx_ack pulses, then after 65535 cycles the FSM returns to IDLE. gmii_tx_en never rises and mac_send_end never pulses.
- Source streams 1600 bytes with no end: 1514 data bytes, tx_trunc pulses once, then a valid FCS over 1514 bytes.
- rstn dropped mid-DATA: gmii_tx_en and gmii_txd are 0 at that edge. A new request after release produces a clean frame.
